reg_bus_master: RTL and testbench

Bus initiator for the asynchronous register bus served by the register-file blocks (generic and tile). It accepts one register read or write command at a time on a valid/ready interface. It sequences the bus through programmable setup, strobe and hold phases, then returns the result on a valid/ready response channel. Used by on-chip sequencers (boot loader, scripted display init) that need to program registers without an external MCU.

---
 rtl/reg_bus_pkg.sv | 51 +++++
 rtl/reg_bus_phase_timer.sv | 29 ++
 rtl/reg_bus_master.sv | 179 +++++++++++++++++
 tb/tb_reg_bus_master.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/reg_bus_pkg.sv
// Shared types and helpers for the register-bus initiator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package reg_bus_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD,
    RB_SETUP,
    RB_STROBE,
    RB_HOLD,
    RESP
  } state_e;

  localparam int DEF_ADDR_WIDTH    = 16;
  localparam int DEF_DATA_WIDTH    = 16;
  localparam int DEF_SETUP_CYCLES  = 1;
  localparam int DEF_STROBE_CYCLES = 2;
  localparam int DEF_HOLD_CYCLES   = 1;

  // Widest data bus the byte-mask compare can handle.
  localparam int MAX_DATA_WIDTH = 64;

  // Width of a down-counter able to hold the longest phase length.
  function automatic int phase_cnt_width(input int s, input int t, input int h);
    int m;
    m = s;
    if (t > m) m = t;
    if (h > m) m = h;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

  // True when a and b agree in every byte lane enabled by be.
  // Lane 0 is the low half of the dw-bit word, lane 1 the high half.
  function automatic logic be_match(input logic [1:0] be,
                                    input logic [MAX_DATA_WIDTH-1:0] a,
                                    input logic [MAX_DATA_WIDTH-1:0] b,
                                    input int dw);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < MAX_DATA_WIDTH; i++) begin
      logic lane;
      lane = (i >= dw / 2);
      if ((i < dw) && be[lane] && (a[i] != b[i])) ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/reg_bus_phase_timer.sv
// Loadable down-counter that times one bus phase; done when it reaches zero.
// Latency: load takes effect on the next edge; a phase of N cycles is loaded with N-1.
// Backpressure: none, counts every cycle and parks at zero.
module reg_bus_phase_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] cnt;

  // Reload on phase entry, otherwise count down and hold at zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/reg_bus_master.sv
// Register-bus initiator: one read/write per command, sequenced SETUP/STROBE/HOLD, optional write readback (REG_BUS_READBACK_EN).
// Latency: cmd accepted at edge k -> bus_en from k+1, rsp_valid from k+1+S+T+H (readback writes add another S+T+H).
// Backpressure: cmd_ready only in IDLE; rsp held stable until rsp_ready, no new command until then.
module reg_bus_master
  import reg_bus_pkg::*;
#(
  parameter int ADDR_WIDTH    = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int SETUP_CYCLES  = DEF_SETUP_CYCLES,
  parameter int STROBE_CYCLES = DEF_STROBE_CYCLES,
  parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [1:0]            cmd_be,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_error,
  output logic                  busy,
  output logic                  bus_en,
  output logic                  bus_rd,
  output logic                  bus_wr,
  output logic [1:0]            bus_be,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [DATA_WIDTH-1:0] bus_wdata,
  input  logic [DATA_WIDTH-1:0] bus_rdata
);

  localparam int CW = phase_cnt_width(SETUP_CYCLES, STROBE_CYCLES, HOLD_CYCLES);

  if (SETUP_CYCLES < 1 || STROBE_CYCLES < 1 || HOLD_CYCLES < 1) begin : g_bad_timing
    $error("reg_bus_master: SETUP/STROBE/HOLD_CYCLES must all be >= 1");
  end

  state_e                state, next_state;
  logic                  write_q;
  logic [1:0]            be_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  tmr_load;
  logic [CW-1:0]         tmr_val;
  logic                  tmr_done;
  logic                  in_bus;
  logic                  rd_phase;
  logic                  wr_phase;
  logic                  cmd_fire;

  assign cmd_ready = (state == IDLE) & ~reset;
  assign cmd_fire  = cmd_valid & cmd_ready;
  assign busy      = (state != IDLE);
  assign rsp_rdata = rdata_q;

  // Bus outputs are registered copies of the phase decode, so they lag state by one cycle.
  assign in_bus   = state inside {SETUP, STROBE, HOLD, RB_SETUP, RB_STROBE, RB_HOLD};
  assign rd_phase = ((state == STROBE) && !write_q) || (state == RB_STROBE);
  assign wr_phase = (state == STROBE) && write_q;

  reg_bus_phase_timer #(.W(CW)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state decode; the phase timer is reloaded whenever a timed phase is entered.
  always_comb begin
    next_state = state;
    tmr_load   = 1'b0;
    tmr_val    = '0;
    case (state)
      IDLE:      if (cmd_valid) next_state = SETUP;
      SETUP:     if (tmr_done) next_state = STROBE;
      STROBE:    if (tmr_done) next_state = HOLD;
`ifdef REG_BUS_READBACK_EN
      HOLD:      if (tmr_done) next_state = write_q ? RB_SETUP : RESP;
`else
      HOLD:      if (tmr_done) next_state = RESP;
`endif
      RB_SETUP:  if (tmr_done) next_state = RB_STROBE;
      RB_STROBE: if (tmr_done) next_state = RB_HOLD;
      RB_HOLD:   if (tmr_done) next_state = RESP;
      RESP:      if (rsp_valid && rsp_ready) next_state = IDLE;
      default:   next_state = IDLE;
    endcase
    if (next_state != state) begin
      case (next_state)
        SETUP, RB_SETUP:   begin tmr_load = 1'b1; tmr_val = CW'(SETUP_CYCLES - 1);  end
        STROBE, RB_STROBE: begin tmr_load = 1'b1; tmr_val = CW'(STROBE_CYCLES - 1); end
        HOLD, RB_HOLD:     begin tmr_load = 1'b1; tmr_val = CW'(HOLD_CYCLES - 1);   end
        default:           tmr_load = 1'b0;
      endcase
    end
  end

  // Command is captured once at acceptance and never re-sampled.
  always_ff @(posedge clk) begin
    if (reset) begin
      write_q <= 1'b0;
      be_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (cmd_fire) begin
      write_q <= cmd_write;
      be_q    <= cmd_be;
      addr_q  <= cmd_addr;
      wdata_q <= cmd_wdata;
    end
  end

  // Glitch-free bus drive: every bus_* is a flop, and all drop together on reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus_en    <= 1'b0;
      bus_rd    <= 1'b0;
      bus_wr    <= 1'b0;
      bus_be    <= '0;
      bus_addr  <= '0;
      bus_wdata <= '0;
    end else begin
      bus_en    <= in_bus;
      bus_rd    <= rd_phase;
      bus_wr    <= wr_phase;
      bus_be    <= in_bus ? be_q : '0;
      bus_addr  <= in_bus ? addr_q : '0;
      bus_wdata <= in_bus ? wdata_q : '0;
    end
  end

  // Read data is sampled on the edge where the read strobe falls (first HOLD cycle); writes report 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_q <= '0;
    end else if (cmd_fire) begin
      rdata_q <= '0;
    end else if (bus_rd && (state == HOLD || state == RB_HOLD)) begin
      rdata_q <= bus_rdata;
    end
  end

  // Response valid rises one cycle into RESP and clears on the handshake.
  always_ff @(posedge clk) begin
    if (reset) rsp_valid <= 1'b0;
    else       rsp_valid <= (state == RESP) && !(rsp_valid && rsp_ready);
  end

`ifdef REG_BUS_READBACK_EN
  logic err_q;

  // Readback compare covers only the byte lanes the write enabled.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if (cmd_fire) begin
      err_q <= 1'b0;
    end else if (bus_rd && (state == RB_HOLD)) begin
      err_q <= ~be_match(be_q, MAX_DATA_WIDTH'(bus_rdata), MAX_DATA_WIDTH'(wdata_q), DATA_WIDTH);
    end
  end

  assign rsp_error = err_q;
`else
  assign rsp_error = 1'b0;
`endif

endmodule

// File: tb/tb_reg_bus_master.sv
module tb_reg_bus_master;

  localparam int AW  = 16;
  localparam int DW  = 16;
  localparam int S   = 1;
  localparam int T   = 2;
  localparam int H   = 1;
  localparam int ACC = S + T + H;
`ifdef REG_BUS_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_write = 1'b0;
  logic [1:0]    cmd_be = '0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_error;
  logic          busy;
  logic          bus_en, bus_rd, bus_wr;
  logic [1:0]    bus_be;
  logic [AW-1:0] bus_addr;
  logic [DW-1:0] bus_wdata;
  logic [DW-1:0] bus_rdata;

  always #5 clk = ~clk;

  reg_bus_master #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
    .SETUP_CYCLES(S), .STROBE_CYCLES(T), .HOLD_CYCLES(H)
  ) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_be(cmd_be), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_error(rsp_error), .busy(busy),
    .bus_en(bus_en), .bus_rd(bus_rd), .bus_wr(bus_wr), .bus_be(bus_be),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata)
  );

  // Target register file: commits on the falling edge of bus_wr, read data is combinational.
  bit   [DW-1:0] tmem    [256];
  bit   [DW-1:0] ref_mem [256];
  logic          force_rd  = 1'b0;
  logic [DW-1:0] force_val = '0;

  assign bus_rdata = force_rd ? force_val : tmem[bus_addr[7:0]];

  always @(negedge bus_wr) begin
    if (!reset) begin
      if (bus_be[0]) tmem[bus_addr[7:0]][7:0]  = bus_wdata[7:0];
      if (bus_be[1]) tmem[bus_addr[7:0]][15:8] = bus_wdata[15:8];
    end
  end

  // Bus activity monitor.
  int en_cnt = 0, rd_cnt = 0, wr_cnt = 0, viol = 0;
  always @(negedge clk) begin
    if (bus_en) en_cnt++;
    if (bus_rd) rd_cnt++;
    if (bus_wr) wr_cnt++;
    if ((bus_rd && bus_wr) || ((bus_rd || bus_wr) && !bus_en)) viol++;
  end

  int checks = 0;
  int errors = 0;
  int s_en, s_rd, s_wr;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic void model_write(input logic [7:0] a, input logic [1:0] be, input logic [DW-1:0] d);
    logic [DW-1:0] m;
    m = {{8{be[1]}}, {8{be[0]}}};
    ref_mem[a] = (ref_mem[a] & ~m) | (d & m);
  endfunction

  // Present a command and wait for its acceptance edge; returns just after the following negedge.
  task automatic issue(input logic wr, input logic [1:0] be, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int w;
    w = 0;
    cmd_write = wr; cmd_be = be; cmd_addr = a; cmd_wdata = d; cmd_valid = 1'b1;
    while (!cmd_ready && w < 40) begin
      @(negedge clk);
      w++;
    end
    check_eq("cmd_wait", w, 0);
    @(posedge clk);
    s_en = en_cnt; s_rd = rd_cnt; s_wr = wr_cnt;
    @(negedge clk);
    cmd_valid = 1'b0;
    check_eq("busy_after_accept", busy, 1'b1);
  endtask

  task automatic wait_rsp(input int exp_lat, input int exp_rd, input int exp_wr, input int exp_en,
                          input logic [DW-1:0] exp_rdata, input logic exp_err, input int hold,
                          input bit pend, input logic [AW-1:0] pend_addr);
    int lat;
    lat = 0;
    while (!rsp_valid && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    check_eq("rsp_latency", lat, exp_lat);
    check_eq("rsp_rdata", rsp_rdata, exp_rdata);
    check_eq("rsp_error", rsp_error, exp_err);
    if (pend) begin
      cmd_write = 1'b0; cmd_be = 2'b11; cmd_addr = pend_addr; cmd_wdata = DW'($urandom); cmd_valid = 1'b1;
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check_eq("hold_rsp_valid", rsp_valid, 1'b1);
      check_eq("hold_rsp_rdata", rsp_rdata, exp_rdata);
      check_eq("hold_cmd_ready", cmd_ready, 1'b0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    check_eq("rd_strobe_cycles", rd_cnt - s_rd, exp_rd);
    check_eq("wr_strobe_cycles", wr_cnt - s_wr, exp_wr);
    check_eq("en_cycles", en_cnt - s_en, exp_en);
    @(negedge clk);
    rsp_ready = 1'b0;
    check_eq("rsp_valid_cleared", rsp_valid, 1'b0);
    check_eq("cmd_ready_after_rsp", cmd_ready, 1'b1);
  endtask

  task automatic txn(input logic wr, input logic [1:0] be, input logic [AW-1:0] a, input logic [DW-1:0] d,
                     input int hold, input logic [DW-1:0] exp_rdata, input logic exp_err);
    int n;
    n = (wr && RB) ? 2 : 1;
    issue(wr, be, a, d);
    wait_rsp(1 + n * ACC, (!wr || RB) ? T : 0, wr ? T : 0, n * ACC, exp_rdata, exp_err, hold, 1'b0, '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    // Reset held three cycles.
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_cmd_ready", cmd_ready, 1'b0);
    check_eq("rst_bus_en", bus_en, 1'b0);
    check_eq("rst_bus_rd", bus_rd, 1'b0);
    check_eq("rst_bus_wr", bus_wr, 1'b0);
    check_eq("rst_bus_addr", bus_addr, 0);
    check_eq("rst_rsp_valid", rsp_valid, 1'b0);
    reset = 1'b0;
    #1;
    check_eq("rel_cmd_ready", cmd_ready, 1'b1);
    check_eq("rel_busy", busy, 1'b0);

    // Directed write, then directed read with the target forcing its data.
    model_write(8'h10, 2'b11, 16'hABCD);
    txn(1'b1, 2'b11, 16'h0010, 16'hABCD, 0, RB ? 16'hABCD : 16'h0000, 1'b0);
    check_eq("target_0010", tmem[8'h10], 16'hABCD);
    force_rd = 1'b1; force_val = 16'h5A5A;
    txn(1'b0, 2'b11, 16'h0002, 16'h0000, 0, 16'h5A5A, 1'b0);
    force_rd = 1'b0;

    // Random traffic against the shadow register file.
    for (int n = 0; n < 24; n++) begin
      logic          wr;
      logic [1:0]    be;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      int            hold;
      wr   = 1'($urandom_range(0, 1));
      be   = 2'($urandom);
      a    = AW'($urandom_range(0, 7));
      d    = DW'($urandom);
      hold = $urandom_range(0, 3);
      if (wr) begin
        model_write(a[7:0], be, d);
        txn(1'b1, be, a, d, hold, RB ? ref_mem[a[7:0]] : '0, 1'b0);
      end else begin
        txn(1'b0, be, a, d, hold, ref_mem[a[7:0]], 1'b0);
      end
    end

    // Backpressure with a second command pending, accepted right after the handshake.
    model_write(8'h03, 2'b11, 16'hC3C3);
    txn(1'b1, 2'b11, 16'h0003, 16'hC3C3, 0, RB ? 16'hC3C3 : 16'h0000, 1'b0);
    issue(1'b0, 2'b11, 16'h0003, 16'h0000);
    wait_rsp(1 + ACC, T, 0, ACC, 16'hC3C3, 1'b0, 5, 1'b1, 16'h0004);
    issue(1'b0, 2'b11, 16'h0004, 16'h0000);
    wait_rsp(1 + ACC, T, 0, ACC, ref_mem[8'h04], 1'b0, 0, 1'b0, '0);

    // Reset during the strobe of a read.
    issue(1'b0, 2'b11, 16'h0005, 16'h0000);
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    check_eq("pre_rst_bus_rd", bus_rd, 1'b1);
    reset = 1'b1;
    @(posedge clk); @(negedge clk);
    check_eq("midrst_bus_en", bus_en, 1'b0);
    check_eq("midrst_bus_rd", bus_rd, 1'b0);
    check_eq("midrst_rsp_valid", rsp_valid, 1'b0);
    reset = 1'b0;
    #1;
    check_eq("midrst_cmd_ready", cmd_ready, 1'b1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check_eq("midrst_no_rsp", rsp_valid, 1'b0);
    end

    // Low-byte write of 0x1234, target returning a matching and then a mismatching low byte.
    model_write(8'h20, 2'b01, 16'h1234);
    force_rd = 1'b1; force_val = 16'hFF34;
    txn(1'b1, 2'b01, 16'h0020, 16'h1234, 1, RB ? 16'hFF34 : 16'h0000, 1'b0);
    force_val = 16'h0035;
    txn(1'b1, 2'b01, 16'h0020, 16'h1234, 1, RB ? 16'h0035 : 16'h0000, RB);
    force_rd = 1'b0;
    check_eq("target_0020_lo", tmem[8'h20][7:0], 8'h34);

    check_eq("bus_protocol_viol", viol, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
